// File: rtl/spi_arb_ctrl.sv
// spi_arb_ctrl: round-robin sequencer sharing one spi_fsm between two requesters.
// Define SPI_ARB_WATCHDOG_EN to add the fin watchdog and the sticky err flag.
module spi_arb_ctrl #(
    parameter int BITS    = 8,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic [BITS-1:0] data0,
    output logic            done0,
    input  logic            req1,
    input  logic [BITS-1:0] data1,
    output logic            done1,
    output logic            spi_en,
    output logic [BITS-1:0] spi_data,
    input  logic            spi_fin,
    output logic            busy,
    output logic            err
);

    localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    if (GAP < 1 || TIMEOUT < 1) begin : g_param_check
        $error("spi_arb_ctrl: GAP and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            en_q, en_d;
    logic [BITS-1:0] data_q, data_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            rr_q, rr_d;
    logic            gnt_q, gnt_d;
    logic            fin_q;
    logic            fin_rise;
    logic            win;
    logic [GW-1:0]   gap_q, gap_d;

`ifdef SPI_ARB_WATCHDOG_EN
    localparam int            WW      = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    // fin already high when XFER is entered must not count as a rise
    assign fin_rise = spi_fin & ~fin_q;

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        data_d  = data_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        gap_d   = gap_q;
        win     = 1'b0;
`ifdef SPI_ARB_WATCHDOG_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    win     = (req0 & req1) ? rr_q : req1;
                    gnt_d   = win;
                    rr_d    = ~win;
                    data_d  = win ? data1 : data0;
                    en_d    = 1'b1;
                    state_d = S_XFER;
`ifdef SPI_ARB_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            S_XFER: begin
                if (fin_rise) begin
                    en_d    = 1'b0;
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
`ifdef SPI_ARB_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            data_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            fin_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            data_q  <= data_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            fin_q   <= spi_fin;
            gap_q   <= gap_d;
        end
    end

`ifdef SPI_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign spi_en   = en_q;
    assign spi_data = data_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_arb_ctrl.sv
// tb_spi_arb_ctrl: randomized transfers against a transaction-level model
// of the round-robin grant order and the transfer/gap timing.
module tb_spi_arb_ctrl;

    localparam int BITS    = 8;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req0 = 1'b0;
    logic            req1 = 1'b0;
    logic            spi_fin = 1'b0;
    logic [BITS-1:0] data0 = '0;
    logic [BITS-1:0] data1 = '0;
    logic            done0, done1, spi_en, busy, err;
    logic [BITS-1:0] spi_data;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;

    spi_arb_ctrl #(
        .BITS(BITS),
        .GAP(GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .data0(data0),
        .done0(done0),
        .req1(req1),
        .data1(data1),
        .done1(done1),
        .spi_en(spi_en),
        .spi_data(spi_data),
        .spi_fin(spi_fin),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // round robin: contested grants follow ptr, a lone request always wins
    function automatic int pick(input bit r0, input bit r1);
        int w;
        w   = (r0 && r1) ? ptr : (r1 ? 1 : 0);
        ptr = 1 - w;
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst && (done0 || done1)) check("no_overlap", 32'(done0 & done1), 0);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int w;
        tick();
        tick();
        check("rst_en", spi_en, 0);
        check("rst_data", spi_data, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick();

        // reset in the middle of a transfer
        req0  = 1'b1;
        data0 = 8'hAA;
        tick();
        w = pick(1, 0);
        check("mid_en", spi_en, 1);
        check("mid_data", spi_data, 8'hAA);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_en", spi_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", {done0, done1}, 0);
        ptr  = 0;
        req0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // both requesters held: strict alternation, GAP+1 cycles done->en
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h11;
        data1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!spi_en && n < 20) begin
                tick();
                n++;
            end
            check(k == 0 ? "b2b_first_lat" : "b2b_gap", n, k == 0 ? 1 : GAP + 1);
            w = pick(1, 1);
            check("b2b_data", spi_data, w ? 8'h22 : 8'h11);
            tick();
            tick();
            spi_fin = 1'b1;
            tick();
            check("b2b_done0", done0, w == 0);
            check("b2b_done1", done1, w == 1);
            spi_fin = 1'b0;
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        repeat (GAP) tick();
        check("b2b_idle", busy, 0);

        for (int it = 0; it < 40; it++) begin
            int              pat;
            int              hold;
            bit              fin_hi;
            logic [BITS-1:0] d0, d1, exp_d;
            pat    = $urandom_range(1, 3);
            d0     = BITS'($urandom);
            d1     = BITS'($urandom);
            fin_hi = ($urandom_range(0, 3) == 0);
            hold   = fin_hi ? $urandom_range(1, 4) : $urandom_range(0, 4);
            req0    = pat[0];
            req1    = pat[1];
            data0   = d0;
            data1   = d1;
            spi_fin = fin_hi;
            check("idle_en", spi_en, 0);
            tick();
            w     = pick(req0, req1);
            exp_d = w ? d1 : d0;
            check("grant_en", spi_en, 1);
            check("grant_data", spi_data, exp_d);
            check("grant_busy", busy, 1);
            check("grant_nodone", {done0, done1}, 0);
            // loser withdraws; winner may drop or keep its request
            if (w == 0) begin
                req1 = 1'b0;
                req0 = 1'($urandom_range(0, 1));
            end else begin
                req0 = 1'b0;
                req1 = 1'($urandom_range(0, 1));
            end
            data0 = BITS'($urandom);
            data1 = BITS'($urandom);
            if (fin_hi) begin
                tick();
                check("finhi_nodone", {done0, done1}, 0);
                check("finhi_en", spi_en, 1);
                spi_fin = 1'b0;
            end
            repeat (hold) begin
                tick();
                check("hold_en", spi_en, 1);
                check("hold_data", spi_data, exp_d);
                check("hold_nodone", {done0, done1}, 0);
            end
            spi_fin = 1'b1;
            tick();
            check("done0", done0, w == 0);
            check("done1", done1, w == 1);
            check("done_en", spi_en, 0);
            check("done_busy", busy, 1);
            check("done_err", err, 0);
            spi_fin = 1'b0;
            req1    = 1'b0;
            req0    = ($urandom_range(0, 1) == 1);
            for (int g = 1; g < GAP; g++) begin
                tick();
                req0 = 1'b0;
                check("gap_en", spi_en, 0);
                check("gap_busy", busy, 1);
                check("gap_nodone", {done0, done1}, 0);
            end
            tick();
            req0 = 1'b0;
            check("gap_end_busy", busy, 0);
            check("gap_end_en", spi_en, 0);
        end

`ifdef SPI_ARB_WATCHDOG_EN
        req1  = 1'b1;
        data1 = 8'h3C;
        tick();
        w    = pick(0, 1);
        req1 = 1'b0;
        n    = 0;
        while (spi_en && n < 200) begin
            tick();
            n++;
            if (done0 || done1) check("wd_nodone", {done0, done1}, 0);
        end
        check("wd_len", n, TIMEOUT);
        check("wd_err", err, 1);
        repeat (GAP) tick();
        req0  = 1'b1;
        data0 = 8'hC3;
        tick();
        w    = pick(1, 0);
        req0 = 1'b0;
        check("wd_next_data", spi_data, 8'hC3);
        spi_fin = 1'b1;
        tick();
        check("wd_next_done", done0, 1);
        check("wd_err_sticky", err, 1);
        spi_fin = 1'b0;
        repeat (GAP) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
